// File: rtl/seq_adder_pkg.sv
// Shared definitions for the multiword adder sequencer: FSM state encoding,
// default geometry and the word-index width helper.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int unsigned SEQ_N_DEFAULT     = 8;
  localparam int unsigned SEQ_WORDS_DEFAULT = 4;

  // Width of the word index counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/multi_bit_full_adder.sv
// N-bit ripple-carry adder slice shared by the multiword sequencer.
module multi_bit_full_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic ripple_c;

  // Ripple the carry through N full-adder bit positions.
  always_comb begin
    sum      = '0;
    ripple_c = cin;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ ripple_c;
      ripple_c = (a[i] & b[i]) | (ripple_c & (a[i] ^ b[i]));
    end
    cout = ripple_c;
  end

endmodule

// File: rtl/multiword_adder_sequencer.sv
// Wide add/subtract built from one N-bit adder reused over WORDS cycles,
// least-significant word first, with valid/ready handshakes on both sides.
// Optional macro SEQ_ADDER_FLAGS_EN adds out_zero and out_overflow ports.
module multiword_adder_sequencer
  import seq_adder_pkg::*;
#(
  parameter int unsigned N     = SEQ_N_DEFAULT,
  parameter int unsigned WORDS = SEQ_WORDS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic               out_carry
`ifdef SEQ_ADDER_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_overflow
`endif
);

  localparam int unsigned W     = N * WORDS;
  localparam int unsigned IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  seq_state_t       state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic [W-1:0]     next_sum;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_slice;
  logic [N-1:0]     b_slice;
  logic [N-1:0]     slice_sum;
  logic             slice_cout;

  // Select the operand slices addressed by the word index.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        a_slice = a_reg[k*N +: N];
        b_slice = b_reg[k*N +: N];
      end
    end
  end

  multi_bit_full_adder #(
    .N(N)
  ) u_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Merge the current slice result into the accumulated sum.
  always_comb begin
    next_sum = sum_reg;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (idx == IDX_W'(k)) begin
        next_sum[k*N +: N] = slice_sum;
      end
    end
  end

  assign out_sum = sum_reg;

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_carry    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carry_reg    <= 1'b0;
      idx          <= '0;
`ifdef SEQ_ADDER_FLAGS_EN
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= in_a;
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= next_sum;
          carry_reg <= slice_cout;
          if (idx == LAST_IDX) begin
            idx          <= '0;
            out_carry    <= slice_cout;
            out_valid    <= 1'b1;
`ifdef SEQ_ADDER_FLAGS_EN
            out_zero     <= (next_sum == '0);
            out_overflow <= (a_reg[W-1] == b_reg[W-1]) && (next_sum[W-1] != a_reg[W-1]);
`endif
            state        <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Directed self-checking bench for multiword_adder_sequencer (N=8, WORDS=4).
module tb_multiword_adder_sequencer;

  localparam int unsigned N = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_carry;
`ifdef SEQ_ADDER_FLAGS_EN
  logic         out_zero;
  logic         out_overflow;
`endif

  int total = 0;
  int bad = 0;

  multiword_adder_sequencer #(
    .N(N),
    .WORDS(WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
`ifdef SEQ_ADDER_FLAGS_EN
    ,
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an operation at a negedge; it is accepted on the following posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_issue", 64'(in_ready), 64'd1);
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sub = 1'b0;
  endtask

  // Wait for out_valid, checking latency and result, then optionally drain.
  task automatic finish_op(input string tag, input logic [W-1:0] exp_sum, input logic exp_carry,
                           input logic exp_zero, input logic exp_ovf, input logic drain);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(WORDS));
    check({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
    check({tag, "_carry"}, 64'(out_carry), 64'(exp_carry));
`ifdef SEQ_ADDER_FLAGS_EN
    check({tag, "_zero"}, 64'(out_zero), 64'(exp_zero));
    check({tag, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
`else
    if (exp_zero === 1'bx || exp_ovf === 1'bx) $display("unexpected unknown flag expectation");
`endif
    if (drain) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
      check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
`ifdef SEQ_ADDER_FLAGS_EN
    check("rst_out_zero", 64'(out_zero), 64'd0);
    check("rst_out_ovf", 64'(out_overflow), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Carry across a word boundary
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    finish_op("add_ff_1", 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full wrap with carry out of the top slice
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op("add_wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);

    // Subtract with borrow, then without
    start_op(32'h0000_0005, 32'h0000_0007, 1'b1);
    finish_op("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    start_op(32'h0000_0007, 32'h0000_0005, 1'b1);
    finish_op("sub_7_5", 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1);

    // Signed overflow
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    finish_op("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);

    // Backpressure: result held while new requests are ignored
    start_op(32'h0000_00FF, 32'h0000_0F01, 1'b0);
    finish_op("bp", 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = 32'hDEAD_BEEF;
      in_b = 32'h1111_1111;
      @(negedge clk);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_sum_hold", 64'(out_sum), 64'h0000_1000);
      check("bp_carry_hold", 64'(out_carry), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bp_no_stray_accept", 64'(in_ready), 64'd1);
    start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
    finish_op("bp_next", 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of an operation
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_result", 64'(out_valid), 64'd0);
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    finish_op("post_rst", 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
